frame_capture_pingpong: RTL and testbench

//  Captures parallel ADC samples on each EOC rising edge into a two-bank ping-pong RAM of FRAME_LEN samples per bank.

---
 rtl/frame_capture_pingpong_pkg.sv | 18 +
 rtl/frame_capture_pingpong_if.sv | 24 ++
 rtl/frame_capture_pingpong_ram.sv | 33 +++
 rtl/frame_capture_pingpong.sv | 137 +++++++++++++
 tb/tb_frame_capture_pingpong.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/frame_capture_pingpong_pkg.sv
// Shared constants and types for the ping-pong frame capture block.
// Defaults for data width and frame length, handshake FSM states, drop-counter helpers.
package frame_capture_pingpong_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FRAME_LEN  = 296;  // analysis window 256 + max lag 40
  localparam int DROP_CNT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } hs_state_e;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_capture_pingpong_if.sv
// Consumer-side port of the frame capture block: frame handshake plus random-access read.
// frame_ready is a level held until the consumer pulses frame_ack for one cycle; while it
// is high the bank in frame_bank is frozen and rd_data returns RAM[frame_bank][rd_addr]
// one cycle after rd_addr is presented.
interface frame_capture_pingpong_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  logic                  frame_ready;
  logic                  frame_bank;
  logic                  frame_ack;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output frame_ready, frame_bank, rd_data,
    input  frame_ack, rd_addr
  );

  modport slave (
    input  frame_ready, frame_bank, rd_data,
    output frame_ack, rd_addr
  );
endinterface

// File: rtl/frame_capture_pingpong_ram.sv
// Two-bank sample store: simple dual-port RAM, depth 2*FRAME_LEN, one write port and
// one registered read port on a single clock. Out-of-range reads return zero.
module fcp_dual_bank_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 296,
  localparam int RAM_AW    = $clog2(2 * FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [RAM_AW-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [RAM_AW-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = 2 * FRAME_LEN;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= re_i ? mem[raddr_i] : '0;
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/frame_capture_pingpong.sv
// ADC frame capture into a ping-pong RAM with ready/ack hand-off to the consumer.
// Optional FCP_PEAK_EN adds frame_peak, the max |sample - midscale| of the held frame.
module frame_capture_pingpong
  import frame_capture_pingpong_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FRAME_LEN   = DEF_FRAME_LEN,
  parameter int SYNC_STAGES = 2,
  localparam int ADDR_WIDTH = $clog2(FRAME_LEN)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     adc_data,
  input  logic                      adc_eoc,
  frame_capture_pingpong_if.master  cons,
  output logic [DROP_CNT_WIDTH-1:0] dropped_cnt,
  output logic                      overrun,
  output hs_state_e                 dbg_state_o
`ifdef FCP_PEAK_EN
  ,
  output logic [DATA_WIDTH-1:0]     frame_peak
`endif
);
  localparam int RAM_AW = $clog2(2 * FRAME_LEN);

  logic [SYNC_STAGES-1:0]    eoc_sync_q;
  logic                      eoc_prev_q;
  logic                      eoc_rise;
  logic [DATA_WIDTH-1:0]     sample_q;
  logic                      wr_pend_q;
  logic [ADDR_WIDTH-1:0]     fill_idx_q, fill_idx_d;
  logic                      fill_bank_q;
  logic                      frame_done, frame_take;
  hs_state_e                 state_q;
  logic                      frame_ready_q, frame_bank_q, overrun_q;
  logic [DROP_CNT_WIDTH-1:0] dropped_cnt_q;
  logic [RAM_AW-1:0]         waddr, raddr;
  logic                      rd_en;

  // One write per EOC rising edge, however long the pulse stays high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eoc_sync_q <= '0;
      eoc_prev_q <= 1'b0;
      sample_q   <= '0;
      wr_pend_q  <= 1'b0;
      fill_idx_q <= '0;
    end else begin
      eoc_sync_q <= {eoc_sync_q[SYNC_STAGES-2:0], adc_eoc};
      eoc_prev_q <= eoc_sync_q[SYNC_STAGES-1];
      wr_pend_q  <= eoc_rise;
      if (eoc_rise) sample_q <= adc_data;
      fill_idx_q <= fill_idx_d;
    end
  end

  assign eoc_rise   = eoc_sync_q[SYNC_STAGES-1] & ~eoc_prev_q;
  assign frame_done = wr_pend_q && (fill_idx_q == ADDR_WIDTH'(FRAME_LEN - 1));
  // An ack in the completing cycle frees the held bank first, so the new frame is kept.
  assign frame_take = frame_done && ((state_q == IDLE) || cons.frame_ack);

  always_comb begin
    fill_idx_d = fill_idx_q;
    if (wr_pend_q) fill_idx_d = frame_done ? '0 : fill_idx_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      frame_ready_q <= 1'b0;
      frame_bank_q  <= 1'b0;
      fill_bank_q   <= 1'b0;
      overrun_q     <= 1'b0;
      dropped_cnt_q <= '0;
    end else begin
      overrun_q <= 1'b0;
      if (frame_take) begin
        state_q       <= HELD;
        frame_ready_q <= 1'b1;
        frame_bank_q  <= fill_bank_q;
        fill_bank_q   <= ~fill_bank_q;
      end else if (state_q == HELD && cons.frame_ack) begin
        state_q       <= IDLE;
        frame_ready_q <= 1'b0;
      end else if (frame_done) begin
        overrun_q     <= 1'b1;
        dropped_cnt_q <= sat_inc(dropped_cnt_q);
      end
    end
  end

  assign waddr = RAM_AW'(fill_idx_q) + (fill_bank_q ? RAM_AW'(FRAME_LEN) : '0);
  assign raddr = RAM_AW'(cons.rd_addr) + (frame_bank_q ? RAM_AW'(FRAME_LEN) : '0);
  assign rd_en = RAM_AW'(cons.rd_addr) < RAM_AW'(FRAME_LEN);

  fcp_dual_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAME_LEN  (FRAME_LEN)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_pend_q),
    .waddr_i (waddr),
    .wdata_i (sample_q),
    .re_i    (rd_en),
    .raddr_i (raddr),
    .rdata_o (cons.rd_data)
  );

  assign cons.frame_ready = frame_ready_q;
  assign cons.frame_bank  = frame_bank_q;
  assign dropped_cnt      = dropped_cnt_q;
  assign overrun          = overrun_q;
  assign dbg_state_o      = state_q;

`ifdef FCP_PEAK_EN
  localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] dev, peak_max, run_max_q, frame_peak_q;

  assign dev      = sample_q[DATA_WIDTH-1] ? (sample_q - MID) : (MID - sample_q);
  assign peak_max = (dev > run_max_q) ? dev : run_max_q;

  // Running max restarts on every completed frame, dropped or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_max_q    <= '0;
      frame_peak_q <= '0;
    end else if (wr_pend_q) begin
      run_max_q <= frame_done ? '0 : peak_max;
      if (frame_take) frame_peak_q <= peak_max;
    end
  end

  assign frame_peak = frame_peak_q;
`endif
endmodule

// File: tb/tb_frame_capture_pingpong.sv
// Directed bench for frame_capture_pingpong with FRAME_LEN=4, DATA_WIDTH=8.
// Define FCP_PEAK_EN for both bench and RTL to cover the frame_peak output.
module tb_frame_capture_pingpong;
  import frame_capture_pingpong_pkg::*;

  localparam int DW = 8;
  localparam int FL = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] adc_data;
  logic          adc_eoc;
  logic [7:0]    dropped_cnt;
  logic          overrun;
  hs_state_e     dbg_state;
`ifdef FCP_PEAK_EN
  logic [DW-1:0] frame_peak;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int ovr_seen = 0;

  frame_capture_pingpong_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cons_if ();

  frame_capture_pingpong #(
    .DATA_WIDTH  (DW),
    .FRAME_LEN   (FL),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .adc_data    (adc_data),
    .adc_eoc     (adc_eoc),
    .cons        (cons_if.master),
    .dropped_cnt (dropped_cnt),
    .overrun     (overrun),
    .dbg_state_o (dbg_state)
`ifdef FCP_PEAK_EN
    ,
    .frame_peak  (frame_peak)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (overrun === 1'b1) ovr_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic eoc_pulse(input logic [DW-1:0] d);
    @(negedge clk);
    adc_data = d;
    adc_eoc  = 1'b1;
    repeat (3) @(negedge clk);
    adc_eoc = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Ack lands exactly in the cycle the last sample of the frame is written.
  task automatic eoc_pulse_ack(input logic [DW-1:0] d);
    @(negedge clk);
    adc_data = d;
    adc_eoc  = 1'b1;
    repeat (3) @(negedge clk);
    adc_eoc          = 1'b0;
    cons_if.frame_ack = 1'b1;
    @(negedge clk);
    cons_if.frame_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    cons_if.frame_ack = 1'b1;
    @(negedge clk);
    cons_if.frame_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    @(negedge clk);
    cons_if.rd_addr = a;
    @(negedge clk);
    check(tag, 32'(cons_if.rd_data), 32'(exp));
  endtask

  task automatic read_frame(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    read_chk({tag, "_rd0"}, 2'd0, e0);
    read_chk({tag, "_rd1"}, 2'd1, e1);
    read_chk({tag, "_rd2"}, 2'd2, e2);
    read_chk({tag, "_rd3"}, 2'd3, e3);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},   32'(cons_if.frame_ready), 32'd0);
    check({tag, "_bank"},    32'(cons_if.frame_bank),  32'd0);
    check({tag, "_rd_data"}, 32'(cons_if.rd_data),     32'd0);
    check({tag, "_dropped"}, 32'(dropped_cnt),         32'd0);
    check({tag, "_overrun"}, 32'(overrun),             32'd0);
    check({tag, "_state"},   32'(dbg_state),           32'(IDLE));
`ifdef FCP_PEAK_EN
    check({tag, "_peak"},    32'(frame_peak),          32'd0);
`endif
  endtask

  initial begin
    reset             = 1'b1;
    adc_data          = '0;
    adc_eoc           = 1'b0;
    cons_if.frame_ack = 1'b0;
    cons_if.rd_addr   = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // first frame lands in bank 0
    eoc_pulse(8'd10); eoc_pulse(8'd20); eoc_pulse(8'd30); eoc_pulse(8'd40);
    check("t1_ready", 32'(cons_if.frame_ready), 32'd1);
    check("t1_bank",  32'(cons_if.frame_bank),  32'd0);
    check("t1_state", 32'(dbg_state),           32'(HELD));
    read_frame("t1", 8'd10, 8'd20, 8'd30, 8'd40);

    // frame 0 held unacked: next full frame is dropped
    eoc_pulse(8'd1); eoc_pulse(8'd2); eoc_pulse(8'd3);
    check("t3_no_early_ovr", 32'(ovr_seen), 32'd0);
    eoc_pulse(8'd4);
    check("t3_ovr_pulses", 32'(ovr_seen),            32'd1);
    check("t3_dropped",    32'(dropped_cnt),         32'd1);
    check("t3_bank",       32'(cons_if.frame_bank),  32'd0);
    check("t3_ready",      32'(cons_if.frame_ready), 32'd1);
    read_frame("t3", 8'd10, 8'd20, 8'd30, 8'd40);

    // long EOC high is a single write: 1 + 2 pulses leave the frame one short
    @(negedge clk);
    adc_data = 8'd55;
    adc_eoc  = 1'b1;
    repeat (20) @(negedge clk);
    adc_eoc = 1'b0;
    repeat (3) @(negedge clk);
    eoc_pulse(8'd56); eoc_pulse(8'd57);
    check("t2_one_write", 32'(ovr_seen), 32'd1);
    eoc_pulse(8'd58);
    check("t2_ovr_pulses", 32'(ovr_seen),    32'd2);
    check("t2_dropped",    32'(dropped_cnt), 32'd2);

    // ack coincides with the completing write of the bank-1 frame
    eoc_pulse(8'd5); eoc_pulse(8'd6); eoc_pulse(8'd7);
    eoc_pulse_ack(8'd8);
    check("t4_ovr_pulses", 32'(ovr_seen),            32'd2);
    check("t4_dropped",    32'(dropped_cnt),         32'd2);
    check("t4_ready",      32'(cons_if.frame_ready), 32'd1);
    check("t4_bank",       32'(cons_if.frame_bank),  32'd1);
    check("t4_state",      32'(dbg_state),           32'(HELD));
    read_frame("t4", 8'd5, 8'd6, 8'd7, 8'd8);
    ack_pulse();
    check("t4_ack_ready", 32'(cons_if.frame_ready), 32'd0);
    check("t4_ack_state", 32'(dbg_state),           32'(IDLE));
    ack_pulse();
    check("t4_idle_ack_ready", 32'(cons_if.frame_ready), 32'd0);
    check("t4_idle_ack_bank",  32'(cons_if.frame_bank),  32'd1);

    // reset mid-frame abandons the partial frame
    eoc_pulse(8'd100); eoc_pulse(8'd101);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("t5_rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    eoc_pulse(8'd128); eoc_pulse(8'd200); eoc_pulse(8'd60); eoc_pulse(8'd130);
    check("t5_ready",   32'(cons_if.frame_ready), 32'd1);
    check("t5_bank",    32'(cons_if.frame_bank),  32'd0);
    check("t5_dropped", 32'(dropped_cnt),         32'd0);
    read_frame("t5", 8'd128, 8'd200, 8'd60, 8'd130);
`ifdef FCP_PEAK_EN
    check("t6_peak", 32'(frame_peak), 32'd72);
`endif

    // 260 dropped frames saturate the counter at 255
    for (int f = 0; f < 260; f++) begin
      for (int s = 0; s < FL; s++) eoc_pulse(8'(f + s));
    end
    check("t6_ovr_pulses", 32'(ovr_seen),            32'd262);
    check("t6_dropped",    32'(dropped_cnt),         32'd255);
    check("t6_ready",      32'(cons_if.frame_ready), 32'd1);
    check("t6_bank",       32'(cons_if.frame_bank),  32'd0);
    read_chk("t6_rd1", 2'd1, 8'd200);
`ifdef FCP_PEAK_EN
    check("t6_peak_kept", 32'(frame_peak), 32'd72);
`endif

    // report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
